// File: rtl/rps_match_sequencer.sv
// rps_match_sequencer: best-of-N Rock-Paper-Scissors round/match controller.
// Drives the ComputerChoice freeze pulse, keeps the score, times the result display
// and hands the player choice back for clearing between rounds.
// Optional build macro: RPS_ROUND_TIMEOUT_EN enables the ARMED forfeit timer.
module rps_match_sequencer #(
    parameter int unsigned WINS_TO_TAKE   = 2,
    parameter int unsigned SHOW_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_button,
    input  logic       start,
    input  logic [1:0] player_choice,
    input  logic [1:0] computer_choice,
    input  logic       player_win,
    output logic       stop_signal,
    output logic       clear_choice,
    output logic       win_led,
    output logic       lose_led,
    output logic       tie_led,
    output logic [3:0] player_score,
    output logic [3:0] computer_score,
    output logic [5:0] round_num,
    output logic       match_over
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_LOCK, S_SAMPLE, S_EVAL, S_SHOW, S_CLEAR, S_DONE
    } state_t;

    localparam logic [3:0] WIN_SCORE = 4'(WINS_TO_TAKE);

    // Reject parameter values outside the supported range at elaboration.
    if (WINS_TO_TAKE < 1 || WINS_TO_TAKE > 15 || SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("rps_match_sequencer: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [1:0]  p_lat_q, p_lat_d;
    logic [1:0]  c_lat_q, c_lat_d;
    logic        w_lat_q, w_lat_d;
    logic [31:0] show_cnt_q, show_cnt_d;
    logic        stop_q, stop_d;
    logic        clear_q, clear_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic        tie_q, tie_d;
    logic [3:0]  pscore_q, pscore_d;
    logic [3:0]  cscore_q, cscore_d;
    logic [5:0]  round_q, round_d;
    logic        over_q, over_d;
`ifdef RPS_ROUND_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    // State and all registered outputs; reset dominates every other input.
    always_ff @(posedge clock) begin
        if (reset_button) begin
            state_q    <= S_IDLE;
            p_lat_q    <= '0;
            c_lat_q    <= '0;
            w_lat_q    <= 1'b0;
            show_cnt_q <= '0;
            stop_q     <= 1'b0;
            clear_q    <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            tie_q      <= 1'b0;
            pscore_q   <= '0;
            cscore_q   <= '0;
            round_q    <= '0;
            over_q     <= 1'b0;
`ifdef RPS_ROUND_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            p_lat_q    <= p_lat_d;
            c_lat_q    <= c_lat_d;
            w_lat_q    <= w_lat_d;
            show_cnt_q <= show_cnt_d;
            stop_q     <= stop_d;
            clear_q    <= clear_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            tie_q      <= tie_d;
            pscore_q   <= pscore_d;
            cscore_q   <= cscore_d;
            round_q    <= round_d;
            over_q     <= over_d;
`ifdef RPS_ROUND_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_d    = state_q;
        p_lat_d    = p_lat_q;
        c_lat_d    = c_lat_q;
        w_lat_d    = w_lat_q;
        show_cnt_d = show_cnt_q;
        stop_d     = 1'b0;
        clear_d    = clear_q;
        win_d      = win_q;
        lose_d     = lose_q;
        tie_d      = tie_q;
        pscore_d   = pscore_q;
        cscore_d   = cscore_q;
        round_d    = round_q;
        over_d     = over_q;
`ifdef RPS_ROUND_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pscore_d = '0;
                    cscore_d = '0;
                    round_d  = '0;
                    win_d    = 1'b0;
                    lose_d   = 1'b0;
                    tie_d    = 1'b0;
                    over_d   = 1'b0;
                    state_d  = S_ARMED;
`ifdef RPS_ROUND_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_ARMED: begin
                if (player_choice != 2'b00) begin
                    p_lat_d = player_choice;
                    stop_d  = 1'b1;
                    state_d = S_LOCK;
                end
`ifdef RPS_ROUND_TIMEOUT_EN
                else if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
                    // Forfeit jumps straight to the display phase as a lost round.
                    if (cscore_q != WIN_SCORE) cscore_d = cscore_q + 4'd1;
                    round_d    = (round_q == 6'd63) ? round_q : round_q + 6'd1;
                    lose_d     = 1'b1;
                    show_cnt_d = '0;
                    state_d    = S_SHOW;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
`endif
            end
            S_LOCK: state_d = S_SAMPLE;
            S_SAMPLE: begin
                c_lat_d = computer_choice;
                w_lat_d = player_win;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (c_lat_q == 2'b00) begin
                    clear_d = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    if (p_lat_q == c_lat_q) begin
                        tie_d = 1'b1;
                    end else if (w_lat_q) begin
                        win_d = 1'b1;
                        if (pscore_q != WIN_SCORE) pscore_d = pscore_q + 4'd1;
                    end else begin
                        lose_d = 1'b1;
                        if (cscore_q != WIN_SCORE) cscore_d = cscore_q + 4'd1;
                    end
                    round_d    = (round_q == 6'd63) ? round_q : round_q + 6'd1;
                    show_cnt_d = '0;
                    state_d    = S_SHOW;
                end
            end
            S_SHOW: begin
                if (show_cnt_q == SHOW_CYCLES - 1) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    tie_d   = 1'b0;
                    clear_d = 1'b1;
                    state_d = S_CLEAR;
                end else begin
                    show_cnt_d = show_cnt_q + 32'd1;
                end
            end
            S_CLEAR: begin
                if (player_choice == 2'b00) begin
                    clear_d = 1'b0;
                    if (pscore_q == WIN_SCORE || cscore_q == WIN_SCORE) begin
                        over_d  = 1'b1;
                        win_d   = (pscore_q == WIN_SCORE);
                        lose_d  = (pscore_q != WIN_SCORE);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ARMED;
`ifdef RPS_ROUND_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stop_signal    = stop_q;
    assign clear_choice   = clear_q;
    assign win_led        = win_q;
    assign lose_led       = lose_q;
    assign tie_led        = tie_q;
    assign player_score   = pscore_q;
    assign computer_score = cscore_q;
    assign round_num      = round_q;
    assign match_over     = over_q;

endmodule

// File: tb/tb_rps_match_sequencer.sv
// Directed testbench for rps_match_sequencer (WINS_TO_TAKE=2, SHOW_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_rps_match_sequencer;

    logic       clock = 1'b0;
    logic       reset_button = 1'b1;
    logic       start = 1'b0;
    logic [1:0] player_choice = 2'b00;
    logic [1:0] computer_choice = 2'b00;
    logic       player_win = 1'b0;
    logic       stop_signal, clear_choice, win_led, lose_led, tie_led, match_over;
    logic [3:0] player_score, computer_score;
    logic [5:0] round_num;

    int n_tests = 0;
    int n_fail  = 0;

    rps_match_sequencer #(
        .WINS_TO_TAKE(2),
        .SHOW_CYCLES(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset_button(reset_button),
        .start(start),
        .player_choice(player_choice),
        .computer_choice(computer_choice),
        .player_win(player_win),
        .stop_signal(stop_signal),
        .clear_choice(clear_choice),
        .win_led(win_led),
        .lose_led(lose_led),
        .tie_led(tie_led),
        .player_score(player_score),
        .computer_score(computer_score),
        .round_num(round_num),
        .match_over(match_over)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Plays one round starting in an ARMED cycle (cycle T); returns in the cycle after CLEAR.
    task automatic play_round(input logic [1:0] p, input logic [1:0] c, input logic w,
                              input logic [2:0] leds_exp, input logic [3:0] ps,
                              input logic [3:0] cs, input logic [5:0] rn, input bit is_void);
        player_choice = p; computer_choice = c; player_win = w;
        tick(); check("stop_t1", 32'(stop_signal), 32'd1);
        tick(); check("stop_t2", 32'(stop_signal), 32'd0);
        tick(); check("leds_eval", 32'({win_led, lose_led, tie_led}), 32'd0);
        check("clear_eval", 32'(clear_choice), 32'd0);
        tick();
        check("pscore", 32'(player_score), 32'(ps));
        check("cscore", 32'(computer_score), 32'(cs));
        check("round_num", 32'(round_num), 32'(rn));
        if (is_void) begin
            check("void_clear_t4", 32'(clear_choice), 32'd1);
            check("void_leds", 32'({win_led, lose_led, tie_led}), 32'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("show_leds", 32'({win_led, lose_led, tie_led}), 32'(leds_exp));
                check("show_clear", 32'(clear_choice), 32'd0);
                tick();
            end
            check("clear_leds", 32'({win_led, lose_led, tie_led}), 32'd0);
            check("clear_t8", 32'(clear_choice), 32'd1);
        end
        player_choice = 2'b00;
        tick(); check("clear_drop", 32'(clear_choice), 32'd0);
    endtask

    initial begin
        tick(); tick();
        reset_button = 1'b0;
        check("reset_outs", 32'({stop_signal, clear_choice, win_led, lose_led, tie_led,
              player_score, computer_score, round_num, match_over}), 32'd0);

        start = 1'b1; tick(); start = 1'b0;

        // leds order {win, lose, tie}
        play_round(2'b01, 2'b11, 1'b1, 3'b100, 4'd1, 4'd0, 6'd1, 1'b0);
        play_round(2'b10, 2'b10, 1'b1, 3'b001, 4'd1, 4'd0, 6'd2, 1'b0);
        play_round(2'b01, 2'b10, 1'b0, 3'b010, 4'd1, 4'd1, 6'd3, 1'b0);
        play_round(2'b11, 2'b00, 1'b1, 3'b000, 4'd1, 4'd1, 6'd3, 1'b1);
        play_round(2'b10, 2'b01, 1'b1, 3'b100, 4'd2, 4'd1, 6'd4, 1'b0);
        check("done_over", 32'(match_over), 32'd1);
        check("done_leds", 32'({win_led, lose_led, tie_led}), 32'b100);
        check("done_pscore", 32'(player_score), 32'd2);
        tick();
        check("done_hold", 32'(match_over), 32'd1);

        start = 1'b1; tick(); start = 1'b0;
        check("restart", 32'({match_over, win_led, player_score, computer_score, round_num}), 32'd0);

        play_round(2'b11, 2'b01, 1'b0, 3'b010, 4'd0, 4'd1, 6'd1, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        check("start_ign_cs", 32'(computer_score), 32'd1);
        check("start_ign_rn", 32'(round_num), 32'd1);

        // Reset while the result is displayed.
        player_choice = 2'b01; computer_choice = 2'b11; player_win = 1'b1;
        tick(); tick(); tick(); tick();
        check("pre_reset_led", 32'(win_led), 32'd1);
        reset_button = 1'b1; tick(); reset_button = 1'b0;
        check("mid_reset", 32'({stop_signal, clear_choice, win_led, lose_led, tie_led,
              player_score, computer_score, round_num, match_over}), 32'd0);
        tick(); tick();
        check("idle_no_stop", 32'(stop_signal), 32'd0);
        player_choice = 2'b00;

        // Computer takes the match.
        start = 1'b1; tick(); start = 1'b0;
        play_round(2'b01, 2'b10, 1'b0, 3'b010, 4'd0, 4'd1, 6'd1, 1'b0);
        play_round(2'b01, 2'b10, 1'b0, 3'b010, 4'd0, 4'd2, 6'd2, 1'b0);
        check("lost_over", 32'(match_over), 32'd1);
        check("lost_leds", 32'({win_led, lose_led, tie_led}), 32'b010);

`ifdef RPS_ROUND_TIMEOUT_EN
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_no_stop", 32'(stop_signal), 32'd0);
        end
        check("to_cscore", 32'(computer_score), 32'd1);
        check("to_round", 32'(round_num), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("to_lose_led", 32'(lose_led), 32'd1);
            tick();
        end
        check("to_clear", 32'(clear_choice), 32'd1);
        check("to_led_off", 32'(lose_led), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
